playbus_blkcopy: RTL and testbench
==================================

Name: playbus_blkcopy

Overview:
Block-transfer sequencer for the PlayBus data bus. It drives the address bus and the ROM/RAM/switch/LED control lines to move a contiguous range of addresses between sources and sinks without operator stepping. Supported transfers are ROM→RAM, switches→RAM fill, and ROM or RAM→LEDs scan with a visible dwell per address. It replaces manual per-address GO presses and sits between the operator controls (GO, switches) and the bus control pins.

Parameters:
DWELL_CYC, 2, clock cycles the LEDs hold each value in LED-scan modes (1..15).

Ports:
CK2HZ  in  1  system clock; all state changes on its rising edge.
n_CLR  in  1  asynchronous active-low reset.
GO  in  1  start request; a transfer starts on the rising edge of GO (GO=1 now, GO=0 on the previous sampled cycle).
ABORT  in  1  stop at the next address boundary.
MODE  in  2  0=ROM→RAM, 1=SW→RAM, 2=ROM→LED, 3=RAM→LED.
START_ADD  in  4  first address.
END_ADD  in  4  last address (inclusive).
ADD  out  4  registered address bus.
n_ROMO, n_RAMO, n_SWBEN  out  1 each  active-low source enables, decoded from state and latched mode.
n_RAMW  out  1  RAM write strobe; equals ~RAMW, where RAMW is a registered strobe.
LEDLTCH  out  1  registered LED latch strobe.
BUSY  out  1  high in every state except IDLE and DONE.
DONE  out  1  high in the DONE state.
XCNT  out  5  number of addresses completed in the current or last transfer (0..16).
St  out  3  state monitor: IDLE=0, SRC=1, WRITE=2, HOLD=3, DWELL=4, DONE=5; values 6 and 7 go to IDLE.

Behaviour:
- Reset (n_CLR=0, asynchronous):
  - State is IDLE; ADD=0, RAMW=0 (n_RAMW=1), LEDLTCH=0, XCNT=0; GO edge register=0; latched mode=0.
  - All source enables are 1 (inactive).
- Reset mid-transfer: all strobes drop immediately. A partially written address is acceptable.
- IDLE:
  - All enables inactive.
  - On a GO rising edge: ADD←START_ADD, latch MODE, XCNT←0, go to SRC.
  - GO held high with no edge does not start a transfer.
- SRC: assert the source enable for the latched mode; next strobe=1 (RAMW for modes 0/1, LEDLTCH for modes 2/3); go to WRITE.
- WRITE: source still enabled; strobe is high during this whole cycle; next strobe=0; go to HOLD.
- HOLD: source still enabled; strobe low (data hold time); XCNT←XCNT+1.
  - Modes 2/3: go to DWELL with the dwell counter at DWELL_CYC−1.
  - Modes 0/1: go to the boundary check.
- DWELL: all enables inactive and the LED latch holds its value; count down; at 0, go to the boundary check.
- Boundary check (combinational on leaving HOLD or DWELL):
  - If ADD==END_ADD or ABORT=1: go to DONE.
  - Otherwise: ADD←ADD+1 mod 16, go to SRC.
- DONE: DONE=1, ADD holds; stay until GO=0, then go to IDLE. A start needs a fresh GO edge.
- Wrap-around: START_ADD>END_ADD wraps 15→0. Length = ((END−START) mod 16)+1. START=END transfers one address; a full 16-address transfer has XCNT=16.
- Timing:
  - 3 cycles per address for modes 0/1.
  - 3+DWELL_CYC cycles per address for modes 2/3.
- Input sampling:
  - MODE, START_ADD and GO edges are ignored while BUSY or DONE.
  - END_ADD is sampled live at each boundary.
- ABORT is never honoured inside SRC/WRITE/HOLD, so a strobe always completes.
- Invariants:
  - At most one source enable is low at any time.
  - RAMW and LEDLTCH are never high together.
  - A strobe is only high while its source is enabled.

Test Plan:
- Mode 0, START=2, END=5, GO pulse:
  - ADD steps 2,3,4,5.
  - n_ROMO=0 and n_RAMW=0 for exactly 1 cycle per address.
  - DONE after 12 cycles in SRC/WRITE/HOLD; XCNT=4.
- Mode 3, START=END=7, DWELL_CYC=2: one LEDLTCH pulse with n_RAMO=0, then 2 DWELL cycles, then DONE; XCNT=1.
- Wrap, mode 1, START=14, END=1: ADD sequence 14,15,0,1; n_SWBEN=0 only in SRC/WRITE/HOLD; XCNT=4.
- ABORT raised during WRITE of address 3 in a 0..9 transfer: address 3 completes (HOLD); DONE with ADD=3, XCNT=4.
- GO held high through DONE: no restart. GO low then high starts again; MODE change while BUSY is ignored.
- n_CLR low during WRITE: n_RAMW=1, LEDLTCH=0, St=0, ADD=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/playbus_blkcopy_if.sv
// rtl/playbus_blkcopy_if.sv - PlayBus block-copy operator controls and bus control pins
interface playbus_blkcopy_if;
  // operator controls
  logic       GO;
  logic       ABORT;
  logic [1:0] MODE;
  logic [3:0] START_ADD;
  logic [3:0] END_ADD;
  // bus drive and status
  logic [3:0] ADD;
  logic       n_ROMO;
  logic       n_RAMO;
  logic       n_SWBEN;
  logic       n_RAMW;
  logic       LEDLTCH;
  logic       BUSY;
  logic       DONE;
  logic [4:0] XCNT;
  logic [2:0] St;

  modport master (
    output GO, ABORT, MODE, START_ADD, END_ADD,
    input  ADD, n_ROMO, n_RAMO, n_SWBEN, n_RAMW, LEDLTCH, BUSY, DONE, XCNT, St
  );

  modport slave (
    input  GO, ABORT, MODE, START_ADD, END_ADD,
    output ADD, n_ROMO, n_RAMO, n_SWBEN, n_RAMW, LEDLTCH, BUSY, DONE, XCNT, St
  );
endinterface

// File: rtl/playbus_blkcopy.sv
// rtl/playbus_blkcopy.sv - block-transfer sequencer driving PlayBus address and control lines
module playbus_blkcopy #(
  parameter int DWELL_CYC = 2
) (
  input  logic              CK2HZ,
  input  logic              n_CLR,
  playbus_blkcopy_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SRC   = 3'd1,
    ST_WRITE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DWELL = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [3:0] DWELL_M1 = 4'(DWELL_CYC - 1);

  state_t     state_q, state_d;
  logic [3:0] add_q, add_d;
  logic       ramw_q, ramw_d;
  logic       led_q, led_d;
  logic [4:0] xcnt_q, xcnt_d;
  logic [1:0] mode_q, mode_d;
  logic [3:0] dwell_q, dwell_d;
  logic       go_q;

  logic go_edge;
  logic led_mode;
  logic at_last;
  logic src_en;

  // a start is a fresh 0->1 of GO; held-high GO never retriggers
  assign go_edge  = bus.GO & ~go_q;
  // modes 2 and 3 target the LEDs, modes 0 and 1 target RAM
  assign led_mode = mode_q[1];
  // END_ADD and ABORT are looked at live, only when an address slot finishes
  assign at_last  = (add_q == bus.END_ADD) | bus.ABORT;
  assign src_en   = (state_q == ST_SRC) | (state_q == ST_WRITE) | (state_q == ST_HOLD);

  // state and datapath registers; reset drops every strobe at once
  always_ff @(posedge CK2HZ or negedge n_CLR) begin
    if (!n_CLR) begin
      state_q <= ST_IDLE;
      add_q   <= 4'd0;
      ramw_q  <= 1'b0;
      led_q   <= 1'b0;
      xcnt_q  <= 5'd0;
      mode_q  <= 2'd0;
      dwell_q <= 4'd0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      add_q   <= add_d;
      ramw_q  <= ramw_d;
      led_q   <= led_d;
      xcnt_q  <= xcnt_d;
      mode_q  <= mode_d;
      dwell_q <= dwell_d;
      go_q    <= bus.GO;
    end
  end

  // next-state and next-datapath decode; strobes are high only in the cycle after SRC
  always_comb begin
    state_d = state_q;
    add_d   = add_q;
    ramw_d  = 1'b0;
    led_d   = 1'b0;
    xcnt_d  = xcnt_q;
    mode_d  = mode_q;
    dwell_d = dwell_q;
    case (state_q)
      ST_IDLE: begin
        if (go_edge) begin
          add_d   = bus.START_ADD;
          mode_d  = bus.MODE;
          xcnt_d  = 5'd0;
          state_d = ST_SRC;
        end
      end
      ST_SRC: begin
        ramw_d  = ~led_mode;
        led_d   = led_mode;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        xcnt_d = xcnt_q + 5'd1;
        if (led_mode) begin
          dwell_d = DWELL_M1;
          state_d = ST_DWELL;
        end else if (at_last) begin
          state_d = ST_DONE;
        end else begin
          add_d   = add_q + 4'd1;
          state_d = ST_SRC;
        end
      end
      ST_DWELL: begin
        if (dwell_q == 4'd0) begin
          if (at_last) begin
            state_d = ST_DONE;
          end else begin
            add_d   = add_q + 4'd1;
            state_d = ST_SRC;
          end
        end else begin
          dwell_d = dwell_q - 4'd1;
        end
      end
      ST_DONE: begin
        if (!bus.GO) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ROM feeds modes 0 and 2, switches mode 1, RAM mode 3; enables only in SRC/WRITE/HOLD
  assign bus.n_ROMO  = ~(src_en & ~mode_q[0]);
  assign bus.n_SWBEN = ~(src_en & (mode_q == 2'd1));
  assign bus.n_RAMO  = ~(src_en & (mode_q == 2'd3));
  assign bus.n_RAMW  = ~ramw_q;
  assign bus.LEDLTCH = led_q;
  assign bus.ADD     = add_q;
  assign bus.XCNT    = xcnt_q;
  assign bus.BUSY    = (state_q != ST_IDLE) & (state_q != ST_DONE);
  assign bus.DONE    = (state_q == ST_DONE);
  assign bus.St      = state_q;

endmodule

// File: tb/tb_playbus_blkcopy.sv
// tb/tb_playbus_blkcopy.sv - randomized model-checked bench for playbus_blkcopy
module tb_playbus_blkcopy;
  localparam int DW = 2;

  logic CK2HZ = 1'b0;
  logic n_CLR = 1'b0;

  playbus_blkcopy_if bus();

  playbus_blkcopy #(.DWELL_CYC(DW)) dut (
    .CK2HZ (CK2HZ),
    .n_CLR (n_CLR),
    .bus   (bus.slave)
  );

  always #5 CK2HZ = ~CK2HZ;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // transfer model: phase 0 idle, 1 moving, 2 finished; idx is the cycle inside an address slot
  int         m_phase = 0;
  int         m_idx   = 0;
  int         m_cnt   = 0;
  logic [3:0] m_addr  = 4'd0;
  logic [1:0] m_mode  = 2'd0;
  bit         m_go_prev = 1'b0;
  bit         m_edge;

  int c_busy, c_ramw, c_led, c_romo, c_ramo, c_swben;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int slot_len(input logic [1:0] m);
    return (m >= 2'd2) ? 3 + DW : 3;
  endfunction

  initial begin
    forever begin
      @(posedge CK2HZ or negedge n_CLR);
      if (!n_CLR) begin
        m_phase = 0; m_idx = 0; m_cnt = 0; m_addr = 4'd0; m_mode = 2'd0; m_go_prev = 1'b0;
      end else begin
        m_edge    = bus.GO && !m_go_prev;
        m_go_prev = bus.GO;
        if (m_phase == 0) begin
          if (m_edge) begin
            m_phase = 1; m_idx = 0; m_cnt = 0;
            m_addr = bus.START_ADD; m_mode = bus.MODE;
          end
        end else if (m_phase == 1) begin
          if (m_idx == 2) m_cnt++;
          if (m_idx == slot_len(m_mode) - 1) begin
            if (m_addr == bus.END_ADD || bus.ABORT) m_phase = 2;
            else begin
              m_addr = (m_addr + 4'd1) % 16;
              m_idx  = 0;
            end
          end else begin
            m_idx++;
          end
        end else begin
          if (!bus.GO) m_phase = 0;
        end
      end
    end
  end

  // compare DUT against the model on every falling edge
  always @(negedge CK2HZ) begin
    logic       srcen, strb;
    logic [2:0] est;
    if (chk_en) begin
      srcen = (m_phase == 1) && (m_idx < 3);
      strb  = (m_phase == 1) && (m_idx == 1);
      if (m_phase == 0)      est = 3'd0;
      else if (m_phase == 2) est = 3'd5;
      else if (m_idx < 3)    est = 3'(m_idx + 1);
      else                   est = 3'd4;
      check("St", bus.St, est);
      check("ADD", bus.ADD, m_addr);
      check("XCNT", bus.XCNT, m_cnt);
      check("BUSY", bus.BUSY, m_phase == 1);
      check("DONE", bus.DONE, m_phase == 2);
      check("n_ROMO", bus.n_ROMO, !(srcen && (m_mode == 0 || m_mode == 2)));
      check("n_SWBEN", bus.n_SWBEN, !(srcen && m_mode == 1));
      check("n_RAMO", bus.n_RAMO, !(srcen && m_mode == 3));
      check("n_RAMW", bus.n_RAMW, !(strb && m_mode < 2));
      check("LEDLTCH", bus.LEDLTCH, strb && m_mode >= 2);
      check("inv_one_src", (!bus.n_ROMO + !bus.n_RAMO + !bus.n_SWBEN) <= 1, 1);
      check("inv_strobes", !(!bus.n_RAMW && bus.LEDLTCH), 1);
      check("inv_strobe_src", !((!bus.n_RAMW || bus.LEDLTCH) && bus.n_ROMO && bus.n_RAMO && bus.n_SWBEN), 1);
    end
  end

  task automatic start(input logic [1:0] m, input logic [3:0] s, input logic [3:0] e, input bit hold_go);
    @(negedge CK2HZ);
    bus.MODE = m; bus.START_ADD = s; bus.END_ADD = e; bus.GO = 1'b1;
    @(negedge CK2HZ);
    if (!hold_go) bus.GO = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    int n;
    n = 0;
    c_busy = 0; c_ramw = 0; c_led = 0; c_romo = 0; c_ramo = 0; c_swben = 0;
    while (n < budget) begin
      if (bus.BUSY) c_busy++;
      if (!bus.n_RAMW) c_ramw++;
      if (bus.LEDLTCH) c_led++;
      if (!bus.n_ROMO) c_romo++;
      if (!bus.n_RAMO) c_ramo++;
      if (!bus.n_SWBEN) c_swben++;
      if (bus.DONE) break;
      @(negedge CK2HZ);
      n++;
      if (rnd) begin
        bus.ABORT = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 59) == 0) bus.END_ADD = 4'($urandom);
        if ($urandom_range(0, 9) == 0) begin
          bus.MODE = 2'($urandom);
          bus.START_ADD = 4'($urandom);
        end
      end
    end
    bus.ABORT = 1'b0;
    check("done_in_budget", bus.DONE, 1);
  endtask

  task automatic wait_state(input logic [2:0] st, input logic [3:0] a);
    int n;
    n = 0;
    while (!(bus.St == st && bus.ADD == a) && n < 200) begin
      @(negedge CK2HZ);
      n++;
    end
    check("reached_state", (bus.St == st) && (bus.ADD == a), 1);
  endtask

  initial begin
    bus.GO = 1'b0; bus.ABORT = 1'b0; bus.MODE = 2'd0; bus.START_ADD = 4'd0; bus.END_ADD = 4'd0;
    repeat (2) @(negedge CK2HZ);
    check("rst_St", bus.St, 0);
    check("rst_ADD", bus.ADD, 0);
    check("rst_n_RAMW", bus.n_RAMW, 1);
    check("rst_enables", {bus.n_ROMO, bus.n_RAMO, bus.n_SWBEN}, 3'b111);
    check("rst_XCNT", bus.XCNT, 0);
    n_CLR = 1'b1;
    chk_en = 1'b1;

    // ROM to RAM 2..5
    start(2'd0, 4'd2, 4'd5, 1'b0);
    wait_done(300, 1'b0);
    check("t1_busy_cycles", c_busy, 12);
    check("t1_ramw_pulses", c_ramw, 4);
    check("t1_romo_cycles", c_romo, 12);
    check("t1_ADD", bus.ADD, 5);
    check("t1_XCNT", bus.XCNT, 4);

    // RAM to LED single address with dwell
    start(2'd3, 4'd7, 4'd7, 1'b0);
    wait_done(300, 1'b0);
    check("t2_busy_cycles", c_busy, 3 + DW);
    check("t2_led_pulses", c_led, 1);
    check("t2_ramo_cycles", c_ramo, 3);
    check("t2_XCNT", bus.XCNT, 1);

    // switch fill wrapping 14..1
    start(2'd1, 4'd14, 4'd1, 1'b0);
    wait_done(300, 1'b0);
    check("t3_swben_cycles", c_swben, 12);
    check("t3_ADD", bus.ADD, 1);
    check("t3_XCNT", bus.XCNT, 4);

    // abort in WRITE of address 3
    start(2'd0, 4'd0, 4'd9, 1'b0);
    wait_state(3'd2, 4'd3);
    bus.ABORT = 1'b1;
    wait_done(300, 1'b0);
    check("t4_ADD", bus.ADD, 3);
    check("t4_XCNT", bus.XCNT, 4);

    // GO held through DONE, then restart with MODE changed mid-transfer
    start(2'd0, 4'd4, 4'd5, 1'b1);
    wait_done(300, 1'b0);
    repeat (4) begin
      @(negedge CK2HZ);
      check("t5_stay_done", bus.St, 5);
    end
    bus.GO = 1'b0;
    @(negedge CK2HZ);
    check("t5_idle", bus.St, 0);
    start(2'd2, 4'd8, 4'd9, 1'b0);
    bus.MODE = 2'd1; bus.START_ADD = 4'd0;
    wait_done(300, 1'b0);
    check("t5_led_pulses", c_led, 2);
    check("t5_ramw_pulses", c_ramw, 0);
    check("t5_ADD", bus.ADD, 9);

    // full 16-address transfer
    start(2'd0, 4'd5, 4'd4, 1'b0);
    wait_done(300, 1'b0);
    check("full_XCNT", bus.XCNT, 16);

    // randomized transfers
    for (int i = 0; i < 30; i++) begin
      start(2'($urandom), 4'($urandom), 4'($urandom), 1'b0);
      wait_done(600, 1'b1);
      repeat ($urandom_range(1, 3)) @(negedge CK2HZ);
    end

    // asynchronous reset during WRITE
    start(2'd0, 4'd0, 4'd9, 1'b0);
    wait_state(3'd2, 4'd1);
    #2 n_CLR = 1'b0;
    #1;
    check("arst_n_RAMW", bus.n_RAMW, 1);
    check("arst_LEDLTCH", bus.LEDLTCH, 0);
    check("arst_St", bus.St, 0);
    check("arst_ADD", bus.ADD, 0);
    @(negedge CK2HZ);
    n_CLR = 1'b1;
    repeat (3) @(negedge CK2HZ);
    check("post_rst_idle", bus.St, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
